// File: rtl/csr_timer_array.sv
// csr_timer_array: CSR-mapped bank of down-counting timers with per-channel
// pending bits, an interrupt mask and a free-running stable counter.
module csr_timer_array #(
    parameter int NCH   = 4,
    parameter int TW    = 32,
    parameter int CNT_W = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           csr_wen,
    input  logic [13:0]    csr_waddr,
    input  logic [31:0]    wdata,
    input  logic           csr_ren,
    input  logic [13:0]    csr_raddr,
    output logic [31:0]    csr_rdata,
    output logic [NCH-1:0] ti_pending,
    output logic           ti_irq
);
    localparam logic [13:0] A_TICLR = 14'h0120;
    localparam logic [13:0] A_TMASK = 14'h0121;
    localparam logic [13:0] A_CNT_L = 14'h0122;
    localparam logic [13:0] A_CNT_H = 14'h0123;
    localparam logic [9:0]  A_CHAN  = 10'h010;

    localparam logic [TW-1:0]    TV_ONE  = TW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [TW-1:0]     cfg  [NCH];
    logic [TW-1:0]     tval [NCH];
    logic [NCH-1:0]    pending;
    logic [NCH-1:0]    mask;
    logic [NCH-1:0]    expire;
    logic [NCH-1:0]    clr;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-33:0] shadow;

    logic       w_cfg;
    logic [2:0] w_idx;
    logic [2:0] r_idx;

    assign w_idx = csr_waddr[3:1];
    assign r_idx = csr_raddr[3:1];

    assign w_cfg = csr_wen && (csr_waddr[13:4] == A_CHAN) && !csr_waddr[0]
                   && ({1'b0, w_idx} < 4'(NCH));

    always_comb begin
        expire = '0;
        for (int i = 0; i < NCH; i++)
            expire[i] = cfg[i][0] && (tval[i] == '0);
    end

    assign clr = (csr_wen && csr_waddr == A_TICLR) ? wdata[NCH-1:0] : '0;

    // A config write overrides the same-cycle expiry action
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                cfg[i]  <= '0;
                tval[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (w_cfg && w_idx == 3'(i)) begin
                    cfg[i]  <= wdata[TW-1:0];
                    tval[i] <= {wdata[TW-1:2], 2'b00};
                end else if (cfg[i][0]) begin
                    if (!expire[i])
                        tval[i] <= tval[i] - TV_ONE;
                    else if (cfg[i][1])
                        tval[i] <= {cfg[i][TW-1:2], 2'b00};
                    else
                        cfg[i][0] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            mask    <= '0;
        end else begin
            pending <= (pending & ~clr) | expire;
            if (csr_wen && csr_waddr == A_TMASK)
                mask <= wdata[NCH-1:0];
        end
    end

    // Upper half is captured on the low-half read so a later high read is coherent
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            shadow <= '0;
        end else begin
            cnt <= cnt + CNT_ONE;
            if (csr_ren && csr_raddr == A_CNT_L)
                shadow <= cnt[CNT_W-1:32];
        end
    end

    always_comb begin
        csr_rdata = '0;
        if (csr_raddr[13:4] == A_CHAN) begin
            for (int i = 0; i < NCH; i++)
                if (r_idx == 3'(i))
                    csr_rdata = csr_raddr[0] ? 32'(tval[i]) : 32'(cfg[i]);
        end else begin
            case (csr_raddr)
                A_TMASK: csr_rdata = 32'(mask);
                A_CNT_L: csr_rdata = cnt[31:0];
                A_CNT_H: csr_rdata = 32'(shadow);
                default: csr_rdata = '0;
            endcase
        end
    end

    assign ti_pending = pending;
    assign ti_irq     = |(pending & mask);

endmodule

// File: tb/tb_csr_timer_array.sv
// tb_csr_timer_array: directed stimulus against an analytic timer model,
// checked every cycle plus hand-computed literal expectations.
module tb_csr_timer_array;
    localparam int NCH = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           csr_wen;
    logic [13:0]    csr_waddr;
    logic [31:0]    wdata;
    logic           csr_ren;
    logic [13:0]    csr_raddr;
    logic [31:0]    csr_rdata;
    logic [NCH-1:0] ti_pending;
    logic           ti_irq;
    logic [31:0]    rdata2;
    logic [1:0]     pend2;
    logic           irq2;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_on = 0;
    bit forced = 0;

    always #5 clk = ~clk;

    csr_timer_array #(.NCH(NCH), .TW(32), .CNT_W(64)) dut (
        .clk(clk), .rst(rst), .csr_wen(csr_wen), .csr_waddr(csr_waddr),
        .wdata(wdata), .csr_ren(csr_ren), .csr_raddr(csr_raddr),
        .csr_rdata(csr_rdata), .ti_pending(ti_pending), .ti_irq(ti_irq)
    );

    csr_timer_array #(.NCH(2), .TW(32), .CNT_W(64)) dut2 (
        .clk(clk), .rst(rst), .csr_wen(csr_wen), .csr_waddr(csr_waddr),
        .wdata(wdata), .csr_ren(csr_ren), .csr_raddr(csr_raddr),
        .csr_rdata(rdata2), .ti_pending(pend2), .ti_irq(irq2)
    );

    // Model: each channel remembers its last config and the edge it was written
    logic [31:0]    m_cfg [NCH] = '{default: '0};
    longint         m_wr  [NCH] = '{default: 0};
    logic [NCH-1:0] m_pend = '0;
    logic [NCH-1:0] m_mask = '0;
    longint         cyc    = 0;

    function automatic longint load_of(int i);
        return longint'({m_cfg[i][31:2], 2'b00});
    endfunction

    function automatic bit en_at(int i, longint n);
        return m_cfg[i][0] && (m_cfg[i][1] || n <= load_of(i));
    endfunction

    function automatic longint tv_at(int i, longint n);
        longint l;
        l = load_of(i);
        if (!m_cfg[i][0]) return l;
        if (m_cfg[i][1]) return l - (n % (l + 1));
        return (n >= l) ? 0 : l - n;
    endfunction

    function automatic logic [31:0] exp_rd(logic [13:0] a);
        int     ch;
        longint n;
        ch = int'(a[3:1]);
        if (a[13:4] == 10'h010) begin
            if (ch >= NCH) return '0;
            n = cyc - m_wr[ch];
            if (a[0]) return 32'(tv_at(ch, n));
            return en_at(ch, n) ? m_cfg[ch] : (m_cfg[ch] & ~32'h1);
        end
        case (a)
            14'h0121: return 32'(m_mask);
            14'h0122: return cyc[31:0];
            default:  return '0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [NCH-1:0] ex;
        logic [NCH-1:0] cl;
        int             wi;
        if (rst) begin
            cyc    = 0;
            m_pend = '0;
            m_mask = '0;
            for (int i = 0; i < NCH; i++) begin
                m_cfg[i] = '0;
                m_wr[i]  = 0;
            end
        end else begin
            for (int i = 0; i < NCH; i++)
                ex[i] = en_at(i, cyc - m_wr[i]) && (tv_at(i, cyc - m_wr[i]) == 0);
            cl = (csr_wen && csr_waddr == 14'h0120) ? wdata[NCH-1:0] : '0;
            m_pend = (m_pend & ~cl) | ex;
            wi = int'(csr_waddr[3:1]);
            if (csr_wen && csr_waddr[13:4] == 10'h010 && !csr_waddr[0] && wi < NCH) begin
                m_cfg[wi] = wdata;
                m_wr[wi]  = cyc + 1;
            end
            if (csr_wen && csr_waddr == 14'h0121)
                m_mask = wdata[NCH-1:0];
            cyc = cyc + 1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_on && !rst) begin
            chk("cyc_pending", 64'(ti_pending), 64'(m_pend));
            chk("cyc_irq", 64'(ti_irq), 64'(|(m_pend & m_mask)));
            if (!(forced && (csr_raddr == 14'h0122 || csr_raddr == 14'h0123)))
                chk("cyc_rdata", 64'(csr_rdata), 64'(exp_rd(csr_raddr)));
        end
    end

    task automatic wr(input logic [13:0] a, input logic [31:0] d);
        csr_wen = 1'b1;
        csr_waddr = a;
        wdata = d;
        @(posedge clk);
        #2;
        csr_wen = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic look(input logic [13:0] a);
        csr_raddr = a;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bit got;
        rst = 1'b1;
        csr_wen = 1'b0;
        csr_ren = 1'b0;
        csr_waddr = '0;
        wdata = '0;
        csr_raddr = 14'h0100;
        #1;
        chk("rst_pending", 64'(ti_pending), 64'h0);
        chk("rst_irq", 64'(ti_irq), 64'h0);
        look(14'h0100);
        chk("rst_tcfg0", 64'(csr_rdata), 64'h0);
        look(14'h0122);
        chk("rst_cnt_l", 64'(csr_rdata), 64'h0);

        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        chk_on = 1;
        idle(1);
        look(14'h0122);
        chk("cnt_first_edge", 64'(csr_rdata), 64'h1);

        // One-shot: 0x11 loads 16, expires on the 17th edge
        wr(14'h0100, 32'h11);
        look(14'h0101);
        chk("os_tval_start", 64'(csr_rdata), 64'd16);
        for (int k = 1; k <= 16; k++) begin
            idle(1);
            chk("os_tval", 64'(csr_rdata), 64'(16 - k));
            chk("os_nopend", 64'(ti_pending[0]), 64'h0);
        end
        idle(1);
        chk("os_pend", 64'(ti_pending[0]), 64'h1);
        look(14'h0100);
        chk("os_cfg_en_clr", 64'(csr_rdata), 64'h10);
        idle(20);
        look(14'h0101);
        chk("os_tval_hold", 64'(csr_rdata), 64'h0);
        wr(14'h0120, 32'h1);
        chk("os_cleared", 64'(ti_pending[0]), 64'h0);
        idle(20);
        chk("os_no_second", 64'(ti_pending[0]), 64'h0);
        wr(14'h0101, 32'hAB);
        look(14'h0101);
        chk("tval_wr_ignored", 64'(csr_rdata), 64'h0);

        // Periodic with mask
        wr(14'h0121, 32'h2);
        wr(14'h0102, 32'h0B);
        look(14'h0103);
        chk("per_tval_start", 64'(csr_rdata), 64'd8);
        idle(8);
        chk("per_nopend", 64'(ti_pending[1]), 64'h0);
        idle(1);
        chk("per_pend", 64'(ti_pending[1]), 64'h1);
        chk("per_irq", 64'(ti_irq), 64'h1);
        chk("per_reload", 64'(csr_rdata), 64'd8);
        wr(14'h0120, 32'h2);
        chk("per_clr", 64'(ti_pending[1]), 64'h0);
        chk("per_clr_irq", 64'(ti_irq), 64'h0);
        for (int k = 0; k < 7; k++) begin
            idle(1);
            chk("per_clr_hold", 64'(ti_pending[1]), 64'h0);
        end
        idle(1);
        chk("per_pend_again", 64'(ti_pending[1]), 64'h1);
        wr(14'h0102, 32'h0);
        wr(14'h0120, 32'h2);

        // Clear on the expiry edge loses to the set
        wr(14'h0100, 32'h09);
        idle(8);
        look(14'h0101);
        chk("race_tval0", 64'(csr_rdata), 64'h0);
        wr(14'h0120, 32'h1);
        chk("set_wins", 64'(ti_pending[0]), 64'h1);
        wr(14'h0120, 32'h1);
        chk("set_cleared", 64'(ti_pending[0]), 64'h0);

        // Config write on the expiry edge; channel 2 is absent in the 2-channel copy
        wr(14'h0104, 32'h05);
        idle(4);
        wr(14'h0104, 32'h0F);
        chk("wr_exp_pend", 64'(ti_pending[2]), 64'h1);
        look(14'h0104);
        chk("wr_exp_cfg", 64'(csr_rdata), 64'h0F);
        chk("nch2_cfg_rd", 64'(rdata2), 64'h0);
        chk("nch2_pend", 64'(pend2), 64'h0);
        look(14'h0105);
        chk("wr_exp_tval", 64'(csr_rdata), 64'd12);

        // Simultaneous expiry on channels 0 and 3
        wr(14'h0120, 32'hF);
        wr(14'h0100, 32'h09);
        idle(3);
        wr(14'h0106, 32'h05);
        idle(4);
        chk("sim_pre", 64'({ti_pending[3], ti_pending[0]}), 64'h0);
        idle(1);
        chk("sim_both", 64'({ti_pending[3], ti_pending[0]}), 64'h3);

        // Unmapped and out-of-range channel addresses
        wr(14'h0108, 32'hFFFF_FFFF);
        wr(14'h0000, 32'hFFFF_FFFF);
        wr(14'h0124, 32'hFFFF_FFFF);
        look(14'h0108);
        chk("unmap_108", 64'(csr_rdata), 64'h0);
        look(14'h0124);
        chk("unmap_124", 64'(csr_rdata), 64'h0);
        look(14'h0120);
        chk("ticlr_rd", 64'(csr_rdata), 64'h0);

        // Coherent 64-bit counter read
        look(14'h0123);
        chk("cnt_h_idle", 64'(csr_rdata), 64'h0);
        forced = 1;
        force dut.cnt = 64'h0000_0001_FFFF_FFFF;
        csr_ren = 1'b1;
        look(14'h0122);
        chk("cnt_l_forced", 64'(csr_rdata), 64'hFFFF_FFFF);
        @(posedge clk);
        #2;
        csr_ren = 1'b0;
        release dut.cnt;
        idle(2);
        look(14'h0123);
        chk("cnt_h_shadow", 64'(csr_rdata), 64'h1);

        // Asynchronous reset mid-count with pending bits set
        wr(14'h0121, 32'h5);
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            if (ti_pending[2]) got = 1;
            else idle(1);
        end
        chk("wait_pend2", 64'(got), 64'h1);
        wr(14'h0100, 32'h07);
        idle(7);
        look(14'h0101);
        chk("pre_rst_tval0", 64'(csr_rdata), 64'd2);
        chk("pre_rst_pend", 64'({ti_pending[2], ti_pending[0]}), 64'h3);
        chk("pre_rst_irq", 64'(ti_irq), 64'h1);
        rst = 1'b1;
        forced = 0;
        #1;
        chk("arst_pending", 64'(ti_pending), 64'h0);
        chk("arst_irq", 64'(ti_irq), 64'h0);
        look(14'h0101);
        chk("arst_tval0", 64'(csr_rdata), 64'h0);
        look(14'h0100);
        chk("arst_tcfg0", 64'(csr_rdata), 64'h0);
        look(14'h0105);
        chk("arst_tval2", 64'(csr_rdata), 64'h0);
        look(14'h0104);
        chk("arst_tcfg2", 64'(csr_rdata), 64'h0);
        look(14'h0121);
        chk("arst_tmask", 64'(csr_rdata), 64'h0);
        look(14'h0123);
        chk("arst_cnt_h", 64'(csr_rdata), 64'h0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        idle(1);
        look(14'h0122);
        chk("cnt_after_rst", 64'(csr_rdata), 64'h1);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/csr_timer_array.md
CSR_TIMER_ARRAY -- requirements
Module: csr_timer_array

Interface
REQ-001 Parameter NCH, default 4, number of independent timer channels; the legal range SHALL be 1..8.
REQ-002 Parameter TW, default 32, timer width in bits; the legal range SHALL be 8..32.
REQ-003 Parameter CNT_W, default 64, stable-counter width; the legal range SHALL be 33..64.
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 csr_wen  in  1  CSR write strobe.
REQ-007 csr_waddr  in  14  CSR write address.
REQ-008 wdata  in  32  CSR write data.
REQ-009 csr_ren  in  1  CSR read strobe; it SHALL be used only for counter snapshot side effects.
REQ-010 csr_raddr  in  14  CSR read address.
REQ-011 csr_rdata  out  32  combinational read data.
REQ-012 ti_pending  out  NCH  per-channel timer-interrupt pending bits.
REQ-013 ti_irq  out  1  combinational OR of (ti_pending & mask).

Function
REQ-014 The address map SHALL be: TCFG_i = 0x0100+2i; TVAL_i = 0x0101+2i; TICLR = 0x0120; TMASK = 0x0121; CNT_L = 0x0122; CNT_H = 0x0123.
REQ-015 TCFG_i SHALL hold fields En=bit0, Periodic=bit1, InitVal=bits[TW-1:2]; bits 31:TW SHALL read 0.
REQ-016 A TCFG_i write SHALL store all fields and SHALL load tval_i = {wdata[TW-1:2],2'b00}, with effect in the next cycle.
REQ-017 When En_i=1 and tval_i != 0, tval_i SHALL decrement by 1 per cycle.
REQ-018 When En_i=1 and tval_i == 0, the block SHALL set pending_i and then act on Periodic:
- Periodic=1: reload tval_i from {InitVal,2'b00}.
- Periodic=0: clear En_i and hold tval_i at 0.
REQ-019 A one-shot timer SHALL set pending exactly once per TCFG write.
REQ-020 A TCFG_i write in the same cycle as an expiry of channel i SHALL win for En, Periodic and tval; pending_i SHALL still be set from the pre-write state.
REQ-021 A TICLR write SHALL clear pending_i for each wdata[i]=1; TICLR SHALL read 0.
REQ-022 If pending_i is set and cleared in the same cycle, set SHALL win.
REQ-023 A TVAL_i read SHALL return the current tval_i, zero-extended; writes to TVAL_i SHALL be ignored.
REQ-024 TMASK SHALL be an NCH-bit read/write register; bits 31:NCH SHALL read 0.
REQ-025 The stable counter SHALL increment by 1 every cycle and wrap from all-ones to 0; it SHALL be read-only.
REQ-026 csr_ren with CNT_L SHALL return cnt[31:0] and latch cnt[CNT_W-1:32] into a shadow register in that cycle.
REQ-027 A CNT_H read SHALL return the shadow, zero-extended; CNT_H SHALL never read the live counter.
REQ-028 Unmapped addresses, and channel addresses for i >= NCH, SHALL read 0 and ignore writes.
REQ-029 Channels SHALL be fully independent; simultaneous expiries on several channels SHALL all set their pending bits in the same cycle.
REQ-030 Read data SHALL be combinational from current state; a write SHALL become visible on the next cycle, with no read/write bypass.

Reset
REQ-031 On rst assertion, at any time including mid-count, all outputs and registers SHALL clear immediately and asynchronously: TCFG, tval, pending, TMASK, counter, shadow, ti_irq = 0.
REQ-032 On rst deassertion, the counter SHALL reach 1 on the first clk edge.

Verification
REQ-033 Write TCFG_0 = 0x11 (En=1, Periodic=0, InitVal=4, tval=16) -> TVAL_0 counts 16..0, pending[0]=1 on the 17th edge after the write, then En_0=0 and tval_0 stays 0 with no second pending.
REQ-034 Write TCFG_1 = 0x0B (Periodic, tval=8) with TMASK = 0x2 -> pending[1] every 9 cycles; ti_irq=1 from the first expiry; a TICLR write of 0x2 clears it for 8 cycles.
REQ-035 Issue a TICLR clear of bit 0 on the exact expiry cycle of channel 0 -> pending[0] remains 1.
REQ-036 Force cnt = 0x0000_0001_FFFF_FFFF, read CNT_L, then read CNT_H 3 cycles later -> CNT_L returns 0xFFFF_FFFF and CNT_H returns 0x1, not 0x2.
REQ-037 Assert rst while channels 0 and 2 are mid-count with pending set -> all TVAL/TCFG/pending read 0 and ti_irq=0 in the same cycle, before any clk edge.
REQ-038 With NCH=2, write TCFG at 0x0104 -> reads back 0 and no pending bit changes.
